dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single 16x4 data memory between two requesters: the CPU load/store port and a debug/loader port that preloads or inspects data memory.
- Per-cycle arbitration with a registered request stage, a registered read-return stage and a debug lock for halted-CPU access.
- Sits between the CPU datapath's memory stage and the data memory. Drives the memory's write enable, address and write data, and consumes its combinational read data.

Parameters:
- ADDR_W, 4, address width (16 words).
- DATA_W, 4, data width.
- DBG_PRIORITY, 0, 0 = round-robin between CPU and debug; 1 = debug wins every conflict.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- cpu_req  input  1  CPU access request; held until granted.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU store data.
- cpu_gnt  output  1  CPU request accepted this cycle (combinational).
- cpu_stall  output  1  cpu_req & ~cpu_gnt; freezes the CPU PC.
- cpu_rvalid  output  1  CPU load data valid (registered).
- cpu_rdata  output  DATA_W  CPU load data (registered).
- dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/ADDR_W/DATA_W  debug request fields, same rules as the CPU fields.
- dbg_lock  input  1  while high, the CPU is never granted.
- dbg_gnt, dbg_rvalid, dbg_rdata  output  1/1/DATA_W  debug counterparts of the CPU outputs.
- mem_we  output  1  memory write enable (registered stage).
- mem_addr  output  ADDR_W  memory address (registered stage).
- mem_wdata  output  DATA_W  memory write data (registered stage).
- mem_rdata  input  DATA_W  memory combinational read data.

Behaviour:
- Clock and reset: single clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_rvalid=0, dbg_rvalid=0, cpu_rdata=0, dbg_rdata=0, stage_valid=0, last_winner=DBG (so the CPU wins the first tie). Grants are 0 while reset is high.
- Grant logic (combinational from inputs and state):
  - Only the CPU requests and dbg_lock=0 -> CPU granted.
  - Only debug requests -> debug granted.
  - Both request, DBG_PRIORITY=1 -> debug granted.
  - Both request, DBG_PRIORITY=0 -> the requester that is not last_winner is granted.
  - dbg_lock=1 -> cpu_gnt=0 regardless of other inputs.
  - At most one grant per cycle. last_winner updates only on a grant.
- Stage register (cycle N = grant cycle):
  - At the end of N: stage_valid=1 and stage_owner/we/addr/wdata are captured from the winner.
  - With no grant: stage_valid=0 and mem_we=0. mem_addr/mem_wdata hold their previous values.
- Memory cycle N+1:
  - mem_we = stage_valid & stage_we; mem_addr and mem_wdata come from the stage register.
  - The memory commits writes at the end of N+1.
- Read return:
  - For a load in stage, mem_rdata is registered into the owner's rdata at the end of N+1, and the owner's rvalid is pulsed high for exactly cycle N+2.
  - Stores never assert rvalid.
  - The non-owner's rdata holds its value.
- Latency and throughput:
  - Load: grant at N -> rvalid at N+2.
  - Store: grant at N -> memory updated at the end of N+1.
  - Throughput: one access per cycle, back-to-back, with no bubbles.
- Ordering: a store granted at N followed by a load of the same address granted at N+1 returns the new data. Accesses reach memory in grant order, so no forwarding is needed.
- Requester rules:
  - Request fields must stay stable while req=1 and gnt=0.
  - Dropping req before a grant is legal: the request is withdrawn with no side effects.
- Reset mid-operation: an in-flight stage entry is discarded. No write is committed and no rvalid is produced in the cycle after reset.
- Address and data are passed through unmodified. There is no wrap logic; the address space is exactly 2^ADDR_W words.

Test Plan:
1. Reset: assert reset 2 cycles with cpu_req=1 -> all outputs 0, no grant. After release with only cpu_req=1 -> cpu_gnt=1 in the first cycle.
2. CPU store then load: store addr 5 data 0xA granted at N, load addr 5 granted at N+1 -> mem_we=1, mem_addr=5 at N+1; cpu_rvalid=1, cpu_rdata=0xA at N+3; cpu_stall=0 throughout.
3. Round-robin conflict (DBG_PRIORITY=0): both request continuously for 4 cycles, CPU loads addr 1, debug loads addr 2 -> grants alternate CPU, DBG, CPU, DBG. The losing side sees cpu_stall=1 in its lost cycles. Each rvalid appears exactly 2 cycles after its grant, with data from the correct address.
4. Fixed priority (DBG_PRIORITY=1): both request for 3 cycles -> dbg_gnt=1 all 3 cycles, cpu_stall=1. cpu_gnt=1 in the cycle after dbg_req drops.
5. Debug lock: dbg_lock=1, cpu_req=1, dbg_req=0 for 5 cycles -> cpu_gnt=0, mem_we=0 throughout. Lock drops -> cpu_gnt=1 the same cycle.
6. Reset mid-operation: debug store addr 3 data 0x7 granted at N, reset asserted at N+1 -> mem_we=0 at N+1, memory word 3 unchanged, no rvalid at N+2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter for the shared data memory
module dmem_arbiter #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 4,
    parameter int DBG_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    logic              last_winner;
    logic              stage_valid;
    logic              stage_owner;
    logic              stage_we;
    logic [ADDR_W-1:0] stage_addr;
    logic [DATA_W-1:0] stage_wdata;
    logic              cpu_ok;
    logic              stage_load;

    // The lock only masks the CPU; debug still competes normally.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        cpu_ok  = cpu_req & ~dbg_lock;
        if (!reset) begin
            if (cpu_ok && dbg_req) begin
                if (DBG_PRIORITY != 0 || last_winner == OWN_CPU)
                    dbg_gnt = 1'b1;
                else
                    cpu_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_ok;
                dbg_gnt = dbg_req;
            end
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt & ~reset;
    assign stage_load = stage_valid & ~stage_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= OWN_DBG;
            stage_valid <= 1'b0;
            stage_owner <= OWN_CPU;
            stage_we    <= 1'b0;
            stage_addr  <= '0;
            stage_wdata <= '0;
            cpu_rvalid  <= 1'b0;
            dbg_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
            dbg_rdata   <= '0;
        end else begin
            stage_valid <= cpu_gnt | dbg_gnt;
            if (cpu_gnt || dbg_gnt) begin
                last_winner <= dbg_gnt;
                stage_owner <= dbg_gnt;
                stage_we    <= dbg_gnt ? dbg_we    : cpu_we;
                stage_addr  <= dbg_gnt ? dbg_addr  : cpu_addr;
                stage_wdata <= dbg_gnt ? dbg_wdata : cpu_wdata;
            end
            cpu_rvalid <= stage_load & (stage_owner == OWN_CPU);
            dbg_rvalid <= stage_load & (stage_owner == OWN_DBG);
            if (stage_load && stage_owner == OWN_CPU)
                cpu_rdata <= mem_rdata;
            if (stage_load && stage_owner == OWN_DBG)
                dbg_rdata <= mem_rdata;
        end
    end

    // Gated by reset so an in-flight store is dropped when reset lands mid-access.
    assign mem_we    = stage_valid & stage_we & ~reset;
    assign mem_addr  = stage_addr;
    assign mem_wdata = stage_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter (round-robin and debug-priority)
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [3:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

    logic       cpu_gnt_a, cpu_stall_a, cpu_rvalid_a, dbg_gnt_a, dbg_rvalid_a, mem_we_a;
    logic [3:0] cpu_rdata_a, dbg_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic       cpu_gnt_b, cpu_stall_b, cpu_rvalid_b, dbg_gnt_b, dbg_rvalid_b, mem_we_b;
    logic [3:0] cpu_rdata_b, dbg_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    logic [3:0] mem_a [16];
    logic [3:0] mem_b [16];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(4), .DBG_PRIORITY(0)) u_a (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt_a), .cpu_stall(cpu_stall_a), .cpu_rvalid(cpu_rvalid_a), .cpu_rdata(cpu_rdata_a),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock),
        .dbg_gnt(dbg_gnt_a), .dbg_rvalid(dbg_rvalid_a), .dbg_rdata(dbg_rdata_a),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    dmem_arbiter #(.ADDR_W(4), .DATA_W(4), .DBG_PRIORITY(1)) u_b (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt_b), .cpu_stall(cpu_stall_b), .cpu_rvalid(cpu_rvalid_b), .cpu_rdata(cpu_rdata_b),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock),
        .dbg_gnt(dbg_gnt_b), .dbg_rvalid(dbg_rvalid_b), .dbg_rdata(dbg_rdata_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    assign mem_rdata_a = mem_a[mem_addr_a];
    assign mem_rdata_b = mem_b[mem_addr_b];

    always @(posedge clk) begin
        if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
        if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 4'(15 - i);
            mem_b[i] = 4'(15 - i);
        end
        reset = 1'b1; dbg_lock = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 4'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 4'h0; dbg_wdata = 4'h0;

        // reset held with cpu_req high
        cyc; #2;
        chk("rst_cpu_gnt", cpu_gnt_a, 0);
        chk("rst_dbg_gnt", dbg_gnt_a, 0);
        chk("rst_mem_we", mem_we_a, 0);
        chk("rst_mem_addr", mem_addr_a, 0);
        chk("rst_mem_wdata", mem_wdata_a, 0);
        chk("rst_cpu_rvalid", cpu_rvalid_a, 0);
        chk("rst_cpu_rdata", cpu_rdata_a, 0);
        chk("rst_dbg_rvalid", dbg_rvalid_a, 0);
        chk("rst_dbg_rdata", dbg_rdata_a, 0);
        cyc; #2;
        chk("rst2_cpu_gnt", cpu_gnt_a, 0);

        // CPU store 5<=A, then load 5
        cyc; reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h5; cpu_wdata = 4'hA; #2;
        chk("st_cpu_gnt", cpu_gnt_a, 1);
        chk("st_cpu_stall", cpu_stall_a, 0);
        cyc; cpu_we = 1'b0; #2;
        chk("ld_cpu_gnt", cpu_gnt_a, 1);
        chk("ld_cpu_stall", cpu_stall_a, 0);
        chk("st_mem_we", mem_we_a, 1);
        chk("st_mem_addr", mem_addr_a, 5);
        chk("st_mem_wdata", mem_wdata_a, 4'hA);
        cyc; idle; #2;
        chk("ld_mem_we", mem_we_a, 0);
        chk("ld_mem_addr", mem_addr_a, 5);
        chk("ld_rvalid_early", cpu_rvalid_a, 0);
        cyc; #2;
        chk("ld_cpu_rvalid", cpu_rvalid_a, 1);
        chk("ld_cpu_rdata", cpu_rdata_a, 4'hA);
        chk("ld_dbg_rvalid", dbg_rvalid_a, 0);
        cyc; #2;
        chk("ld_rvalid_pulse", cpu_rvalid_a, 0);

        // lone debug load of addr 3 makes DBG the last winner
        cyc; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'h3; #2;
        chk("dl_dbg_gnt", dbg_gnt_a, 1);
        chk("dl_cpu_gnt", cpu_gnt_a, 0);

        // round-robin conflict: CPU loads 1 (E), debug loads 2 (D)
        cyc; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h1; dbg_addr = 4'h2; #2;
        chk("rr1_cpu_gnt", cpu_gnt_a, 1);
        chk("rr1_dbg_gnt", dbg_gnt_a, 0);
        chk("rr1_stall", cpu_stall_a, 0);
        cyc; #2;
        chk("rr2_dbg_gnt", dbg_gnt_a, 1);
        chk("rr2_cpu_gnt", cpu_gnt_a, 0);
        chk("rr2_stall", cpu_stall_a, 1);
        chk("rr2_dbg_rvalid", dbg_rvalid_a, 1);
        chk("rr2_dbg_rdata", dbg_rdata_a, 4'hC);
        chk("rr2_cpu_rvalid", cpu_rvalid_a, 0);
        cyc; #2;
        chk("rr3_cpu_gnt", cpu_gnt_a, 1);
        chk("rr3_stall", cpu_stall_a, 0);
        chk("rr3_cpu_rvalid", cpu_rvalid_a, 1);
        chk("rr3_cpu_rdata", cpu_rdata_a, 4'hE);
        chk("rr3_dbg_rvalid", dbg_rvalid_a, 0);
        cyc; #2;
        chk("rr4_dbg_gnt", dbg_gnt_a, 1);
        chk("rr4_stall", cpu_stall_a, 1);
        chk("rr4_dbg_rvalid", dbg_rvalid_a, 1);
        chk("rr4_dbg_rdata", dbg_rdata_a, 4'hD);
        chk("rr4_cpu_rvalid", cpu_rvalid_a, 0);
        chk("rr4_cpu_rdata_hold", cpu_rdata_a, 4'hE);
        cyc; idle; #2;
        chk("rr5_cpu_rvalid", cpu_rvalid_a, 1);
        chk("rr5_cpu_rdata", cpu_rdata_a, 4'hE);
        cyc; #2;
        chk("rr6_dbg_rvalid", dbg_rvalid_a, 1);
        chk("rr6_dbg_rdata", dbg_rdata_a, 4'hD);
        chk("rr6_cpu_rvalid", cpu_rvalid_a, 0);

        // fixed debug priority on the second instance
        cyc; cpu_req = 1'b1; dbg_req = 1'b1; #2;
        chk("pr1_dbg_gnt", dbg_gnt_b, 1);
        chk("pr1_stall", cpu_stall_b, 1);
        cyc; #2;
        chk("pr2_dbg_gnt", dbg_gnt_b, 1);
        chk("pr2_stall", cpu_stall_b, 1);
        cyc; #2;
        chk("pr3_dbg_gnt", dbg_gnt_b, 1);
        chk("pr3_stall", cpu_stall_b, 1);
        cyc; dbg_req = 1'b0; #2;
        chk("pr4_cpu_gnt", cpu_gnt_b, 1);
        chk("pr4_stall", cpu_stall_b, 0);
        cyc; idle; #2;
        cyc; #2;

        // debug lock holding off a CPU store of 7<=5
        for (int i = 0; i < 5; i++) begin
            cyc; dbg_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h7; cpu_wdata = 4'h5; #2;
            chk("lk_cpu_gnt", cpu_gnt_a, 0);
            chk("lk_mem_we", mem_we_a, 0);
            chk("lk_stall", cpu_stall_a, 1);
        end
        cyc; dbg_lock = 1'b0; #2;
        chk("unlk_cpu_gnt", cpu_gnt_a, 1);
        cyc; idle; #2;
        chk("unlk_mem_we", mem_we_a, 1);
        chk("unlk_mem_addr", mem_addr_a, 7);
        chk("unlk_mem_wdata", mem_wdata_a, 5);
        cyc; #2;
        chk("unlk_mem7", mem_a[7], 5);

        // reset lands on a debug store of 3<=7
        cyc; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'h3; dbg_wdata = 4'h7; #2;
        chk("mr_dbg_gnt", dbg_gnt_a, 1);
        cyc; reset = 1'b1; dbg_req = 1'b0; #2;
        chk("mr_mem_we", mem_we_a, 0);
        chk("mr_dbg_gnt_rst", dbg_gnt_a, 0);
        cyc; reset = 1'b0; #2;
        chk("mr_dbg_rvalid", dbg_rvalid_a, 0);
        chk("mr_mem_we_after", mem_we_a, 0);
        chk("mr_mem_addr", mem_addr_a, 0);
        chk("mr_mem3_a", mem_a[3], 4'hC);
        chk("mr_mem3_b", mem_b[3], 4'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
